// File: rtl/fpu_pkg.sv
// fpu_pkg: shared encodings, widths, state enum and flag indices for the fpu
// request arbiter and its round-robin helper.
package fpu_pkg;

    localparam int FP_W  = 23;
    localparam int EXP_W = 7;
    localparam int MAN_W = 15;

    localparam logic [EXP_W-1:0] EXP_INF  = 7'b0111111;
    localparam logic [EXP_W-1:0] EXP_ZERO = 7'b1000000;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_ILL = 2'b11
    } fpu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } arb_state_e;

    localparam int FL_UNF  = 0;
    localparam int FL_OVF  = 1;
    localparam int FL_ZERO = 2;
    localparam int FL_ILL  = 3;
    localparam int FL_TMO  = 4;

    typedef struct packed {
        fpu_op_e         op;
        logic            id;
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
    } arb_req_t;

endpackage

// File: rtl/fpu_rr_arb.sv
// fpu_rr_arb: 2-way round-robin grant; ptr names the port preferred on the
// next contended grant and always points away from the last winner.
module fpu_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       ptr
);

    logic hit;
    logic win;

    assign hit   = enable && (valid != 2'b00);
    assign win   = valid[ptr] ? ptr : ~ptr;
    assign grant = hit ? (2'b01 << win) : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (hit) begin
            ptr <= ~win;
        end
    end

endmodule

// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter: shares one fpu between two requesters with round-robin
// grant and tagged responses. FPU_ARB_TIMEOUT_EN adds a wait-state abort.
module fpu_req_arbiter
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [3:0]      req_op,
    input  logic [2*FP_W-1:0] req_a,
    input  logic [2*FP_W-1:0] req_b,
    output logic            fpu_add,
    output logic            fpu_sub,
    output logic            fpu_mul,
    output logic [FP_W-1:0] fpu_a,
    output logic [FP_W-1:0] fpu_b,
    input  logic            fpu_idle,
    input  logic [FP_W-1:0] fpu_res,
    input  logic [2:0]      fpu_flags,
    output logic            rsp_valid,
    output logic            rsp_id,
    output logic [FP_W-1:0] rsp_data,
    output logic [4:0]      rsp_flags,
    output logic            busy
);

    arb_state_e      state;
    arb_state_e      state_d;
    arb_req_t        cur;
    logic [1:0]      grant;
    logic            rr_ptr;
    logic            gnt_id;
    fpu_op_e         gnt_op;
    logic [FP_W-1:0] gnt_a;
    logic [FP_W-1:0] gnt_b;
    logic            tmo_hit;
    logic            rsp_load;
    logic            rsp_id_d;
    logic [FP_W-1:0] rsp_data_d;
    logic [4:0]      rsp_flags_d;

    fpu_rr_arb u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (req_valid),
        .enable (state == S_IDLE && fpu_idle),
        .grant  (grant),
        .ptr    (rr_ptr)
    );

    assign gnt_id = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    assign gnt_op = fpu_op_e'(gnt_id ? req_op[3:2] : req_op[1:0]);
    assign gnt_a  = gnt_id ? req_a[2*FP_W-1:FP_W] : req_a[FP_W-1:0];
    assign gnt_b  = gnt_id ? req_b[2*FP_W-1:FP_W] : req_b[FP_W-1:0];

`ifdef FPU_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic       waiting;
    logic [7:0] tmo_cnt;

    assign waiting = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
    assign tmo_hit = waiting && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == S_ISSUE) begin
            tmo_cnt <= 8'd1;
        end else if (waiting) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state;
        rsp_load    = 1'b0;
        rsp_id_d    = cur.id;
        rsp_data_d  = '0;
        rsp_flags_d = '0;
        unique case (state)
            S_IDLE: begin
                if (grant != 2'b00) begin
                    if (gnt_op == OP_ILL) begin
                        state_d             = S_RESP;
                        rsp_load            = 1'b1;
                        rsp_id_d            = gnt_id;
                        rsp_flags_d[FL_ILL] = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!fpu_idle) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (fpu_idle) begin
                    state_d          = S_RESP;
                    rsp_load         = 1'b1;
                    rsp_data_d       = fpu_res;
                    rsp_flags_d[2:0] = fpu_flags;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (tmo_hit && !rsp_load) begin
            state_d             = S_RESP;
            rsp_load            = 1'b1;
            rsp_data_d          = '0;
            rsp_flags_d         = '0;
            rsp_flags_d[FL_TMO] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cur       <= '0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_flags <= '0;
        end else begin
            state <= state_d;
            if (grant != 2'b00) begin
                cur <= '{op: gnt_op, id: gnt_id, a: gnt_a, b: gnt_b};
            end
            if (rsp_load) begin
                rsp_id    <= rsp_id_d;
                rsp_data  <= rsp_data_d;
                rsp_flags <= rsp_flags_d;
            end
        end
    end

    always_comb begin
        fpu_add = 1'b0;
        fpu_sub = 1'b0;
        fpu_mul = 1'b0;
        if (state == S_ISSUE) begin
            unique case (cur.op)
                OP_ADD:  fpu_add = 1'b1;
                OP_SUB:  fpu_sub = 1'b1;
                OP_MUL:  fpu_mul = 1'b1;
                default: ;
            endcase
        end
    end

    assign req_ready = grant;
    assign fpu_a     = cur.a;
    assign fpu_b     = cur.b;
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

endmodule
